// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: fetch/decode/exec/mem/writeback control FSM
// with bounded memory handshakes, sticky trap reporting and a retire counter.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    input  logic        branch_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] retired_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_MEM    = 3'b100,
        S_WB     = 3'b101,
        S_TRAP   = 3'b110
    } state_t;

    state_t              state_q, state_d, after_retire;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                ir_load, retire, wait_inc, trap_set;
    logic [1:0]          cause_d;
    logic                is_load, is_store, is_branch, is_jump, op_valid;

    assign state = state_q;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        op_valid  = 1'b1;
        case (ir[6:0])
            OP_LOAD:                  is_load   = 1'b1;
            OP_STORE:                 is_store  = 1'b1;
            OP_BRANCH:                is_branch = 1'b1;
            OP_JAL, OP_JALR:          is_jump   = 1'b1;
            OP_R, OP_IMM, OP_LUI, OP_AUIPC: ;
            default:                  op_valid  = 1'b0;
        endcase
    end

    assign after_retire = run ? S_FETCH : S_IDLE;

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = 2'b00;
        rf_we    = 1'b0;
        wb_sel   = 2'b00;
        ir_load  = 1'b0;
        retire   = 1'b0;
        wait_inc = 1'b0;
        trap_set = 1'b0;
        cause_d  = 2'b00;
        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                // An ack always wins over a timeout landing in the same cycle.
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d  = S_TRAP;
                    trap_set = 1'b1;
                    cause_d  = 2'b10;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                if (op_valid) begin
                    state_d = S_EXEC;
                end else begin
                    state_d  = S_TRAP;
                    trap_set = 1'b1;
                    cause_d  = 2'b01;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_en   = 1'b1;
                    pc_sel  = branch_taken ? 2'b01 : 2'b00;
                    retire  = 1'b1;
                    state_d = after_retire;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    if (is_store) begin
                        pc_en   = 1'b1;
                        retire  = 1'b1;
                        state_d = after_retire;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d  = S_TRAP;
                    trap_set = 1'b1;
                    cause_d  = 2'b11;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_en   = 1'b1;
                wb_sel  = is_load ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
                pc_sel  = is_jump ? 2'b10 : 2'b00;
                retire  = 1'b1;
                state_d = after_retire;
            end
            S_TRAP: ;
            default: begin
                state_d  = S_TRAP;
                trap_set = 1'b1;
                cause_d  = 2'b01;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ir          <= '0;
            trap        <= 1'b0;
            trap_cause  <= 2'b00;
            retired_cnt <= '0;
            wait_cnt    <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load) ir <= imem_rdata;
            if (trap_set) begin
                trap       <= 1'b1;
                trap_cause <= cause_d;
            end
            if (retire) retired_cnt <= retired_cnt + 32'd1;
            // Any state change restarts the wait count, so FETCH/MEM entry sees zero.
            if (state_d != state_q) wait_cnt <= '0;
            else if (wait_inc)      wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: instruction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_multicycle_sequencer;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset, run, imem_ack, branch_taken, dmem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req, dmem_req, dmem_we, pc_en, rf_we, trap;
    logic [1:0]  pc_sel, wb_sel, trap_cause;
    logic [2:0]  state;
    logic [31:0] ir, retired_cnt;

    int errors = 0;
    int checks = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .state(state), .trap(trap), .trap_cause(trap_cause),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    // Instruction classes: 0 = illegal, 1 R, 2 LOAD, 3 IMM, 4 LUI, 5 AUIPC, 6 JAL, 7 JALR, 8 STORE, 9 BRANCH
    function automatic int opc(input logic [31:0] w);
        case (w[6:0])
            7'b0110011: return 1;
            7'b0000011: return 2;
            7'b0010011: return 3;
            7'b0110111: return 4;
            7'b0010111: return 5;
            7'b1101111: return 6;
            7'b1100111: return 7;
            7'b0100011: return 8;
            7'b1100011: return 9;
            default:    return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase number follows the spec encoding, waits count cycles spent.
    int          m_state;
    logic [31:0] m_ir, m_ret;
    int          m_wait;
    logic        m_trap;
    logic [1:0]  m_cause;
    bit          chk_en = 1'b0;

    task automatic model_retire();
        m_ret   = m_ret + 32'd1;
        m_state = run ? 1 : 0;
        m_wait  = 0;
    endtask

    task automatic model_trap(input logic [1:0] c);
        m_state = 6;
        m_trap  = 1'b1;
        m_cause = c;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_state = 0; m_ir = '0; m_ret = '0; m_wait = 0; m_trap = 1'b0; m_cause = 2'b00;
        end else begin
            case (m_state)
                0: if (run) begin m_state = 1; m_wait = 0; end
                1: if (imem_ack) begin
                       m_ir = imem_rdata; m_state = 2;
                   end else begin
                       m_wait++;
                       if (m_wait >= TO) model_trap(2'b10);
                   end
                2: if (opc(m_ir) == 0) model_trap(2'b01); else m_state = 3;
                3: if (opc(m_ir) == 9) model_retire();
                   else if (opc(m_ir) == 2 || opc(m_ir) == 8) begin m_state = 4; m_wait = 0; end
                   else m_state = 5;
                4: if (dmem_ack) begin
                       if (opc(m_ir) == 8) model_retire(); else m_state = 5;
                   end else begin
                       m_wait++;
                       if (m_wait >= TO) model_trap(2'b11);
                   end
                5: model_retire();
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int  k;
            bit  e_pc_en;
            logic [1:0] e_pc_sel, e_wb_sel;
            k        = opc(m_ir);
            e_pc_en  = (m_state == 3 && k == 9) || (m_state == 4 && k == 8 && dmem_ack) || m_state == 5;
            e_pc_sel = (m_state == 3 && k == 9 && branch_taken) ? 2'b01 :
                       (m_state == 5 && (k == 6 || k == 7)) ? 2'b10 : 2'b00;
            e_wb_sel = (k == 2) ? 2'b01 : ((k == 6 || k == 7) ? 2'b10 : 2'b00);
            check("state", 32'(state), 32'(m_state));
            check("ir", ir, m_ir);
            check("retired_cnt", retired_cnt, m_ret);
            check("trap", 32'(trap), 32'(m_trap));
            check("trap_cause", 32'(trap_cause), 32'(m_cause));
            check("imem_req", 32'(imem_req), 32'(m_state == 1));
            check("dmem_req", 32'(dmem_req), 32'(m_state == 4));
            check("dmem_we", 32'(dmem_we), 32'(m_state == 4 && k == 8));
            check("rf_we", 32'(rf_we), 32'(m_state == 5));
            check("pc_en", 32'(pc_en), 32'(e_pc_en));
            if (e_pc_en) check("pc_sel", 32'(pc_sel), 32'(e_pc_sel));
            if (m_state == 5) check("wb_sel", 32'(wb_sel), 32'(e_wb_sel));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drives one instruction through the handshakes until it retires or traps.
    // Acks outside their own phase are deliberately held high to show they are ignored.
    task automatic do_instr(input logic [31:0] instr, input int iwait, input int dwait,
                            input bit taken, input bit drop_run,
                            output int mem_cyc, output bit saw_rf,
                            output logic [1:0] ex_pc_sel, output logic [1:0] wb_seen);
        int          fcnt = 0;
        int          mcnt = 0;
        bit          done = 1'b0;
        logic [31:0] r0   = m_ret;
        mem_cyc = 0; saw_rf = 1'b0; ex_pc_sel = 2'b00; wb_seen = 2'b00;
        for (int i = 0; i < 60 && !done; i++) begin
            imem_ack = 1'b1; dmem_ack = 1'b1; branch_taken = taken; imem_rdata = 32'hFFFF_FFFF;
            case (m_state)
                1: begin imem_rdata = instr; imem_ack = (fcnt == iwait); fcnt++; end
                4: begin dmem_ack = (mcnt == dwait); mcnt++; if (drop_run) run = 1'b0; end
                default: ;
            endcase
            #1;
            if (state == 3'b100) mem_cyc++;
            if (rf_we) saw_rf = 1'b1;
            if (state == 3'b011) ex_pc_sel = pc_sel;
            if (state == 3'b101) wb_seen = wb_sel;
            step();
            if (m_ret != r0 || m_state == 6) done = 1'b1;
        end
        imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
        check("instr_done", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int          mc;
        bit          rf;
        logic [1:0]  eps, wbs;
        logic [31:0] table_ops [7];
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        branch_taken = 1'b0; imem_rdata = '0;
        step();
        chk_en = 1'b1;
        step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_retired", retired_cnt, 32'd0);
        reset = 1'b0; run = 1'b1;

        do_instr(32'h003100B3, 0, 0, 1'b0, 1'b0, mc, rf, eps, wbs);
        check("add_retired", retired_cnt, 32'd1);
        check("add_back_fetch", 32'(state), 32'd1);
        check("add_wb_sel", 32'(wbs), 32'd0);
        check("add_rf_we", 32'(rf), 32'd1);

        do_instr(32'h00002083, 2, 3, 1'b0, 1'b0, mc, rf, eps, wbs);
        check("lw_mem_cycles", 32'(mc), 32'd4);
        check("lw_wb_sel", 32'(wbs), 32'd1);
        check("lw_rf_we", 32'(rf), 32'd1);

        do_instr(32'h00000063, 0, 0, 1'b1, 1'b0, mc, rf, eps, wbs);
        check("beq_pc_sel", 32'(eps), 32'd1);
        check("beq_no_rf_we", 32'(rf), 32'd0);
        check("beq_next_fetch", 32'(state), 32'd1);

        table_ops = '{32'h000010B7, 32'h00001097, 32'h000000EF, 32'h000080E7,
                      32'h00100093, 32'h00112023, 32'h00209063};
        foreach (table_ops[i]) do_instr(table_ops[i], i % 3, i % 2, 1'b0, 1'b0, mc, rf, eps, wbs);
        check("table_retired", retired_cnt, 32'd10);

        do_instr(32'h000000EF, 0, 0, 1'b0, 1'b0, mc, rf, eps, wbs);
        check("jal_wb_sel", 32'(wbs), 32'd2);

        do_instr(32'h003100B3, TO - 1, 0, 1'b0, 1'b0, mc, rf, eps, wbs);
        check("late_ack_no_trap", 32'(trap), 32'd0);
        check("late_ack_retired", retired_cnt, 32'd12);

        do_instr(32'h00112023, 0, 2, 1'b0, 1'b1, mc, rf, eps, wbs);
        check("sw_drop_idle", 32'(state), 32'd0);
        check("sw_drop_retired", retired_cnt, 32'd13);

        force dut.retired_cnt = 32'hFFFF_FFFF;
        m_ret = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        release dut.retired_cnt;
        run = 1'b1;
        do_instr(32'h003100B3, 0, 0, 1'b0, 1'b0, mc, rf, eps, wbs);
        check("wrap_retired", retired_cnt, 32'd0);

        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        check("midreset_state", 32'(state), 32'd0);
        check("midreset_ir", ir, 32'd0);
        reset = 1'b0;

        do_instr(32'h003100B3, 99, 0, 1'b0, 1'b0, mc, rf, eps, wbs);
        check("fetch_to_trap", 32'(trap), 32'd1);
        check("fetch_to_cause", 32'(trap_cause), 32'd2);
        do_reset();

        do_instr(32'h00002083, 0, 99, 1'b0, 1'b0, mc, rf, eps, wbs);
        check("mem_to_cause", 32'(trap_cause), 32'd3);
        do_reset();

        do_instr(32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, mc, rf, eps, wbs);
        check("illegal_cause", 32'(trap_cause), 32'd1);
        for (int i = 0; i < 100; i++) begin
            imem_ack = i[0]; dmem_ack = ~i[0]; run = i[1];
            step();
        end
        check("trap_sticky", 32'(trap), 32'd1);
        check("trap_state", 32'(state), 32'd6);
        do_reset();
        check("trap_reset_state", 32'(state), 32'd0);
        check("trap_reset_flag", 32'(trap), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum cycles a memory request may wait for its acknowledge.
REQ-002 SHALL have port clk, in, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, in, 1: synchronous active-high reset.
REQ-004 SHALL have port run, in, 1: enables instruction sequencing.
REQ-005 SHALL have ports imem_req (out, 1), imem_ack (in, 1) and imem_rdata (in, 32): the instruction fetch handshake.
REQ-006 SHALL have port ir, out, 32: the latched instruction word, driven to the control decoder.
REQ-007 SHALL have port branch_taken, in, 1: the branch comparator result, sampled in EXEC.
REQ-008 SHALL have ports dmem_req (out, 1), dmem_we (out, 1) and dmem_ack (in, 1): the data memory handshake.
REQ-009 SHALL have ports pc_en (out, 1) and pc_sel (out, 2): PC update strobe and source select; 00 = PC+4, 01 = branch target, 10 = jump target.
REQ-010 SHALL have ports rf_we (out, 1) and wb_sel (out, 2): register-file write strobe and writeback source; 00 = ALU, 01 = memory, 10 = PC+4.
REQ-011 SHALL have ports state (out, 3), trap (out, 1) and trap_cause (out, 2): FSM state, sticky trap flag and trap reason.
REQ-012 SHALL have port retired_cnt, out, 32: count of retired instructions.

Function
REQ-013 State encoding SHALL be: IDLE=000, FETCH=001, DECODE=010, EXEC=011, MEM=100, WB=101, TRAP=110; code 111 SHALL go to TRAP with trap_cause=01.
REQ-014 IDLE: run=1 -> FETCH on the next edge; otherwise remain in IDLE.
REQ-015 FETCH: imem_req=1 (Moore output); on imem_ack=1, ir <= imem_rdata and go to DECODE; ack in the first FETCH cycle is valid.
REQ-016 Opcode classes from ir[6:0]: R=0110011, LOAD=0000011, IMM=0010011, LUI=0110111, AUIPC=0010111, JAL=1101111, JALR=1100111, STORE=0100011, BRANCH=1100011.
REQ-017 DECODE SHALL take one cycle; any opcode outside REQ-016 -> TRAP with trap_cause=01; otherwise -> EXEC.
REQ-018 EXEC SHALL take one cycle; LOAD/STORE -> MEM; R/IMM/LUI/AUIPC/JAL/JALR -> WB.
REQ-019 EXEC with BRANCH: pc_en=1, pc_sel=01 if branch_taken else 00; the instruction retires; next state is FETCH if run=1 else IDLE.
REQ-020 MEM: dmem_req=1; dmem_we=1 only for STORE; wait for dmem_ack. On ack, LOAD -> WB; STORE asserts pc_en=1, pc_sel=00, retires, then goes to FETCH/IDLE per run.
REQ-021 WB: rf_we=1 for one cycle and pc_en=1; wb_sel=01 for LOAD, 10 for JAL/JALR, 00 otherwise; pc_sel=10 for JAL/JALR, else 00; the instruction retires; next state is FETCH/IDLE per run.
REQ-022 rf_we, pc_en, imem_req and dmem_req SHALL be 0 in every state or case not listed above; each retire asserts pc_en for exactly one cycle.
REQ-023 run=0 mid-instruction SHALL NOT abort the instruction; it completes, then the FSM goes to IDLE.
REQ-024 Wait counter: cleared on entry to FETCH/MEM; increments each cycle without ack. Reaching MEM_TIMEOUT without ack -> TRAP with trap_cause=10 (FETCH) or 11 (MEM); ack in the same cycle the count reaches MEM_TIMEOUT takes priority over timeout.
REQ-025 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-026 TRAP: trap=1 and all strobes 0; the FSM stays in TRAP until reset; trap_cause holds its value.
REQ-027 retired_cnt SHALL increment by 1 per retire and wrap from 0xFFFFFFFF to 0.

Reset
REQ-028 reset=1 at a clock edge SHALL force state=IDLE, ir=0, trap=0, trap_cause=00, retired_cnt=0 and wait counter=0, with all strobes 0; reset overrides every other input, including mid-handshake and in TRAP.

Verification
REQ-029 ADD x1,x2,x3 (0x003100B3) with imem_ack in the first FETCH cycle, run=1 -> FETCH, DECODE, EXEC, WB; rf_we=1 and wb_sel=00 in WB; retired_cnt=1; back in FETCH on cycle 5.
REQ-030 LW (opcode 0000011), dmem_ack after 3 wait cycles -> MEM held 4 cycles with dmem_we=0; then WB with wb_sel=01 and rf_we=1.
REQ-031 BEQ with branch_taken=1 -> pc_en=1 and pc_sel=01 in EXEC; rf_we never asserted; next state FETCH.
REQ-032 ir=0xFFFFFFFF -> TRAP after DECODE with trap_cause=01; trap stays 1 for 100 cycles; reset returns the FSM to IDLE with trap=0.
REQ-033 imem_ack held low with MEM_TIMEOUT=15 -> TRAP with trap_cause=10 after 15 FETCH cycles; ack on the 15th cycle instead -> DECODE, no trap.
REQ-034 retired_cnt preset to 0xFFFFFFFF by forcing, then one retire -> 0; run dropped during MEM of a STORE -> the store completes, retired_cnt increments, FSM goes to IDLE.
